fetch_m: RTL and testbench
==========================

// Module: fetch_m
// PURPOSE
//  LEGv8 instruction-fetch stage; sits directly upstream of the decoder.
//  Holds the PC, issues req/ack reads to instruction memory, and buffers
//  fetched words in a small FIFO. Presents {instruction, instrPC} to the
//  decoder under a valid/ready handshake.
//  Redirects the PC on taken branches using the decoder's word-offset
//  immediate.
// PARAMETERS
//  RESET_PC  32'h0000_0000  PC after reset; bits [1:0] must be 0
//  DEPTH     2              instruction buffer entries; power of two, >=2
// PORTS
//  clk             in   1   single clock, rising edge
//  rst_n           in   1   asynchronous, active-low reset
//  imemReq         out  1   fetch request
//  imemAddr        out  32  byte address of requested word
//  imemAck         in   1   request accepted; imemData valid this cycle
//  imemData        in   32  instruction word
//  instrValid      out  1   buffer head valid toward decoder
//  instrReady      in   1   decoder accepts head this cycle
//  instruction     out  32  head instruction word
//  instrPC         out  32  byte address of head instruction
//  branchTaken     in   1   redirect strobe (from branch resolution)
//  branchPC        in   32  PC of the resolved branch
//  immediate       in   32  signed word offset from decoder
// BEHAVIOUR
//  Reset (async):
//   - pc=RESET_PC; FIFO empty; imemReq=0; instrValid=0.
//   - instruction=0; instrPC=0.
//  Fetch:
//   - imemReq=1 whenever the FIFO is not full and no redirect is present
//     this cycle.
//   - imemAddr=pc, held stable while imemReq && !imemAck.
//   - One outstanding request at most. The ack may arrive in the request
//     cycle or any later cycle.
//   - Ack (no redirect): push {imemData, pc}; pc <= pc+4, wrapping
//     32'hFFFF_FFFC -> 0.
//  Output:
//   - instruction and instrPC are the registered FIFO head.
//   - Latency ack -> instrValid is 1 cycle.
//   - Pop when instrValid && instrReady.
//   - Head is stable while instrValid && !instrReady.
//  FIFO boundaries:
//   - Push+pop in the same cycle: count unchanged.
//   - Full: imemReq=0, so no push can occur.
//   - Empty: instrValid=0; instruction/instrPC hold their last values.
//   - Pointers wrap modulo DEPTH.
//  Redirect (branchTaken=1 in cycle t):
//   - target = branchPC + {immediate[29:0],2'b00}, modulo 2^32.
//   - At edge t: pc <= target; FIFO flushed; a pop in cycle t is ignored.
//   - An imemAck in cycle t is discarded: no push, no pc+4.
//   - imemReq=0 in cycle t. Memory treats a request withdrawn before
//     ack as cancelled.
//   - From t+1: imemReq=1, imemAddr=target; instrValid=0 until the first
//     post-redirect ack.
//  Reset asserted mid-operation: all state cleared immediately;
//   in-flight ack ignored.
// CONFIGURATION
//  FETCH_PERF_EN defined:
//   - adds output fetchCount[31:0], reset 0.
//   - +1 per pop (instrValid && instrReady && !branchTaken).
//   - wraps at 2^32.
//  FETCH_PERF_EN undefined:
//   - port and counter absent; otherwise identical behaviour.
// TESTING
//  1 Mem acks same cycle with data=addr^32'hA5A5_0000, instrReady=1 ->
//    instrPC 0,4,8,... one per cycle; first instrValid 1 cycle after
//    first ack.
//  2 instrReady=0 after reset -> 2 words buffered (PC 0,4); imemReq drops;
//    head holds PC 0. Raise ready -> PC 0,4,8 in order, no gap/duplicate.
//  3 branchTaken with branchPC=0x10, immediate=-2 -> next imemAddr=0x08;
//    buffered PC 0x14/0x18 never presented.
//  4 branchTaken in same cycle as an ack for 0x0C, target 0x40 -> 0x0C
//    never presented; next instrPC=0x40.
//  5 Ack delayed 3 cycles -> imemAddr stable during wait. rst_n=0
//    mid-wait -> instrValid=0, imemReq=0 immediately; restart at RESET_PC.
//  6 RESET_PC=32'hFFFF_FFF8 -> instrPC FFFF_FFF8, FFFF_FFFC, 0000_0000.
//    With FETCH_PERF_EN: fetchCount=3 after three pops.

Source files
------------

// File: rtl/fetch_m.sv
// ----------------------------------------------------------------------------
// fetch_m : LEGv8 instruction-fetch stage
//
// Purpose
//   Holds the program counter and requests instruction words from
//   instruction memory over a req/ack interface. Fetched words are kept in a
//   small FIFO together with the byte address they came from. The FIFO head
//   goes to the decoder under a valid/ready handshake. A taken branch
//   redirects the PC to branchPC + (immediate * 4) and flushes everything
//   that was fetched down the old path.
//
// Handshakes
//   Memory side: imemReq/imemAddr describe one request. The request
//     completes in the first cycle in which imemReq && imemAck. If imemReq
//     drops before an ack arrives, memory treats the request as cancelled.
//     At most one request is outstanding.
//   Decoder side: instrValid/instruction/instrPC form a standard valid/ready
//     source. The head transfers in any cycle where instrValid && instrReady.
//     While instrValid && !instrReady, the head stays unchanged.
//
// Parameters
//   RESET_PC  PC loaded by reset. Bits [1:0] must be zero.
//   DEPTH     Number of FIFO entries. Must be a power of two, >= 2.
//
// Ports
//   clk          in   1   clock, rising edge
//   rst_n        in   1   asynchronous active-low reset
//   imemReq      out  1   fetch request
//   imemAddr     out  32  byte address of the requested word
//   imemAck      in   1   request accepted; imemData valid this cycle
//   imemData     in   32  instruction word
//   instrValid   out  1   FIFO head valid toward the decoder
//   instrReady   in   1   decoder accepts the head this cycle
//   instruction  out  32  head instruction word (registered)
//   instrPC      out  32  byte address of the head instruction (registered)
//   branchTaken  in   1   redirect strobe
//   branchPC     in   32  PC of the resolved branch
//   immediate    in   32  signed word offset
//   fetchCount   out  32  instructions delivered to the decoder
//                         (only when FETCH_PERF_EN is defined)
//
// Configuration
//   FETCH_PERF_EN  When defined, adds the fetchCount output and its counter.
//                  When undefined, the port and counter are absent.
// ----------------------------------------------------------------------------
module fetch_m #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imemReq,
    output logic [31:0] imemAddr,
    input  logic        imemAck,
    input  logic [31:0] imemData,
    output logic        instrValid,
    input  logic        instrReady,
    output logic [31:0] instruction,
    output logic [31:0] instrPC,
    input  logic        branchTaken,
    input  logic [31:0] branchPC,
    input  logic [31:0] immediate
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0] fetchCount
`endif
);

    localparam int               PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int               CNT_W    = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [31:0]      r_pc;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic [31:0]      r_instr;
    logic [31:0]      r_instr_pc;

    // The buffer storage needs no reset: an entry is never read before it
    // has been written, because occupancy is tracked by r_count.
    logic [31:0]      r_mem_data [DEPTH];
    logic [31:0]      r_mem_pc   [DEPTH];

    // ------------------------------------------------------------------
    // Combinational control
    // ------------------------------------------------------------------
    logic             w_full;
    logic             w_empty;
    logic             w_fetch_en;
    logic             w_push;
    logic             w_pop;
    logic [31:0]      w_target;
    logic [31:0]      w_pc_inc;
    logic [PTR_W-1:0] w_wr_ptr_nxt;
    logic [PTR_W-1:0] w_rd_ptr_nxt;
    logic [CNT_W-1:0] w_count_nxt;
    logic             w_head_from_push;
    logic [31:0]      w_head_data;
    logic [31:0]      w_head_pc;
    logic             w_unused_imm_hi;

    assign w_full  = (r_count == FULL_CNT);
    assign w_empty = (r_count == '0);

    // A request is made only when the buffer has room, no redirect is
    // happening this cycle, and reset is released. Because a request is never
    // raised while full, an ack can never arrive into a full buffer.
    assign w_fetch_en = rst_n && !w_full && !branchTaken;

    // An ack counts only against a live request. During a redirect cycle the
    // request is withdrawn, so an ack in that cycle is dropped here.
    assign w_push = imemAck && w_fetch_en;

    // A redirect kills any pop in the same cycle; the entry is flushed anyway.
    assign w_pop  = !w_empty && instrReady && !branchTaken;

    // The immediate is a word offset. Bits [31:30] are shifted out, which
    // gives the modulo-2^32 byte offset.
    assign w_target        = branchPC + {immediate[29:0], 2'b00};
    assign w_unused_imm_hi = &{1'b0, immediate[31:30]};

    // Wraps 32'hFFFF_FFFC -> 0 through natural 32-bit overflow.
    assign w_pc_inc = r_pc + 32'd4;

    // Pointers wrap modulo DEPTH through natural overflow (DEPTH is 2^PTR_W).
    assign w_wr_ptr_nxt = w_push ? (r_wr_ptr + PTR_W'(1)) : r_wr_ptr;
    assign w_rd_ptr_nxt = w_pop  ? (r_rd_ptr + PTR_W'(1)) : r_rd_ptr;

    always_comb begin
        w_count_nxt = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + CNT_W'(1);
            2'b01:   w_count_nxt = r_count - CNT_W'(1);
            default: w_count_nxt = r_count;
        endcase
    end

    // The next head is the word being written this cycle in one case: the
    // next read pointer lands on the slot the write pointer is filling. This
    // happens on a push into an empty buffer, or on a push and pop together
    // when only one entry is held. Otherwise, the next head is already in
    // storage.
    assign w_head_from_push = w_push && (w_rd_ptr_nxt == r_wr_ptr);

    always_comb begin
        w_head_data = r_mem_data[w_rd_ptr_nxt];
        w_head_pc   = r_mem_pc[w_rd_ptr_nxt];
        if (w_head_from_push) begin
            w_head_data = imemData;
            w_head_pc   = r_pc;
        end
    end

    // ------------------------------------------------------------------
    // Sequential state
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc       <= RESET_PC;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_instr    <= '0;
            r_instr_pc <= '0;
        end else if (branchTaken) begin
            // Redirect: new PC, buffer flushed. The output registers keep
            // their last value, and instrValid drops with r_count.
            r_pc     <= w_target;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_pc <= w_pc_inc;
            end
            r_wr_ptr <= w_wr_ptr_nxt;
            r_rd_ptr <= w_rd_ptr_nxt;
            r_count  <= w_count_nxt;
            // Reload the head registers only when something will be
            // presented. When the buffer drains, they hold their last value.
            if (w_count_nxt != '0) begin
                r_instr    <= w_head_data;
                r_instr_pc <= w_head_pc;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_data[r_wr_ptr] <= imemData;
            r_mem_pc[r_wr_ptr]   <= r_pc;
        end
    end

`ifdef FETCH_PERF_EN
    logic [31:0] r_fetch_count;

    // Counts every transfer to the decoder. A pop is already suppressed
    // during a redirect. Wraps at 2^32.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fetch_count <= '0;
        end else if (w_pop) begin
            r_fetch_count <= r_fetch_count + 32'd1;
        end
    end

    assign fetchCount = r_fetch_count;
`endif

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign imemReq     = w_fetch_en;
    assign imemAddr    = r_pc;
    assign instrValid  = !w_empty;
    assign instruction = r_instr;
    assign instrPC     = r_instr_pc;

endmodule

// File: tb/tb_fetch_m.sv
`timescale 1ns/1ps
module tb_fetch_m;

    localparam int          DEPTH   = 2;
    localparam logic [31:0] WRAP_PC = 32'hFFFF_FFF8;
    localparam logic [31:0] XOR_PAT = 32'hA5A5_0000;

    // ------------------------------------------------------------------
    // Clock / reset
    // ------------------------------------------------------------------
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // Main DUT (RESET_PC = 0)
    logic        imemReq;
    logic [31:0] imemAddr;
    logic        imemAck     = 1'b0;
    logic [31:0] imemData    = 32'h0;
    logic        instrValid;
    logic        instrReady  = 1'b0;
    logic [31:0] instruction;
    logic [31:0] instrPC;
    logic        branchTaken = 1'b0;
    logic [31:0] branchPC    = 32'h0;
    logic [31:0] immediate   = 32'h0;

    // Wrap-around DUT (RESET_PC = FFFF_FFF8), zero-latency memory, always ready
    logic        w_req;
    logic [31:0] w_addr;
    logic        w_valid;
    logic [31:0] w_instr;
    logic [31:0] w_pc;

`ifdef FETCH_PERF_EN
    logic [31:0] fetchCount;
    logic [31:0] w_fetchCount;
`endif

    fetch_m #(.RESET_PC(32'h0), .DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .imemReq     (imemReq),
        .imemAddr    (imemAddr),
        .imemAck     (imemAck),
        .imemData    (imemData),
        .instrValid  (instrValid),
        .instrReady  (instrReady),
        .instruction (instruction),
        .instrPC     (instrPC),
        .branchTaken (branchTaken),
        .branchPC    (branchPC),
        .immediate   (immediate)
`ifdef FETCH_PERF_EN
        ,
        .fetchCount  (fetchCount)
`endif
    );

    fetch_m #(.RESET_PC(WRAP_PC), .DEPTH(DEPTH)) dut_w (
        .clk         (clk),
        .rst_n       (rst_n),
        .imemReq     (w_req),
        .imemAddr    (w_addr),
        .imemAck     (w_req),
        .imemData    (w_addr ^ XOR_PAT),
        .instrValid  (w_valid),
        .instrReady  (1'b1),
        .instruction (w_instr),
        .instrPC     (w_pc),
        .branchTaken (1'b0),
        .branchPC    (32'h0),
        .immediate   (32'h0)
`ifdef FETCH_PERF_EN
        ,
        .fetchCount  (w_fetchCount)
`endif
    );

    // ------------------------------------------------------------------
    // Scoreboard and reference model
    // ------------------------------------------------------------------
    int n_checks = 0;
    int n_fail   = 0;

    // Each entry is {instruction, pc}, in fetch order.
    logic [63:0] exp_q[$];
    logic [31:0] model_pc   = 32'h0;
    logic [63:0] shown      = 64'h0;
    logic [31:0] model_pops = 32'h0;

    function automatic void check32(input string name, input logic [31:0] act,
                                    input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endfunction

    // The model advances at each clock edge from the inputs of the cycle
    // that is ending.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_q.delete();
            model_pc   = 32'h0;
            shown      = 64'h0;
            model_pops = 32'h0;
        end else if (branchTaken) begin
            exp_q.delete();
            model_pc = branchPC + (immediate << 2);
        end else if (imemAck) begin
            exp_q.push_back({imemData, model_pc});
            model_pc = model_pc + 32'd4;
        end
    end

    // Monitor: compares the outputs mid-cycle and pops on a transfer.
    always @(negedge clk) begin
        logic exp_req;
        logic exp_valid;
        exp_req   = rst_n && !branchTaken && (exp_q.size() < DEPTH);
        exp_valid = rst_n && (exp_q.size() != 0);
        check32("imemReq", 32'(imemReq), 32'(exp_req));
        if (exp_req) check32("imemAddr", imemAddr, model_pc);
        check32("instrValid", 32'(instrValid), 32'(exp_valid));
        if (exp_valid) shown = exp_q[0];
        check32("instruction", instruction, shown[63:32]);
        check32("instrPC", instrPC, shown[31:0]);
`ifdef FETCH_PERF_EN
        check32("fetchCount", fetchCount, model_pops);
`endif
        if (exp_valid && instrReady && !branchTaken) begin
            void'(exp_q.pop_front());
            model_pops = model_pops + 32'd1;
        end
    end

    // Monitor for the wrap-around instance: one word per cycle from WRAP_PC.
    logic [31:0] w_exp_pc = WRAP_PC;
    logic [31:0] w_pops   = 32'h0;
    int          w_cyc    = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            w_exp_pc = WRAP_PC;
            w_pops   = 32'h0;
            w_cyc    = 0;
            check32("w_rst_valid", 32'(w_valid), 32'h0);
            check32("w_rst_req", 32'(w_req), 32'h0);
        end else begin
            check32("w_instrValid", 32'(w_valid), 32'(w_cyc >= 1));
`ifdef FETCH_PERF_EN
            check32("w_fetchCount", w_fetchCount, w_pops);
`endif
            if (w_cyc >= 1) begin
                check32("w_instrPC", w_pc, w_exp_pc);
                check32("w_instruction", w_instr, w_exp_pc ^ XOR_PAT);
                w_exp_pc = w_exp_pc + 32'd4;
                w_pops   = w_pops + 32'd1;
            end
            w_cyc++;
        end
    end

    // ------------------------------------------------------------------
    // Driver tasks
    // ------------------------------------------------------------------
    int lat_left = 0;

    // Drives one cycle of stimulus just after the rising edge. The memory
    // acks a live request after lat_left idle cycles. force_ack acks
    // regardless (used to collide an ack with a redirect).
    task automatic drive_cycle(input logic rdy, input logic br,
                               input logic [31:0] bpc, input logic [31:0] imm,
                               input int lat_max, input logic force_ack);
        logic req_exp;
        @(posedge clk);
        #1;
        instrReady  = rdy;
        branchTaken = br;
        branchPC    = bpc;
        immediate   = imm;
        imemAck     = 1'b0;
        req_exp     = rst_n && !br && (exp_q.size() < DEPTH);
        if (force_ack) begin
            imemAck  = 1'b1;
            imemData = model_pc ^ XOR_PAT;
        end else if (req_exp) begin
            if (lat_left == 0) begin
                imemAck  = 1'b1;
                imemData = model_pc ^ XOR_PAT;
                lat_left = int'($urandom_range(lat_max, 0));
            end else begin
                lat_left--;
            end
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n       = 1'b0;
        imemAck     = 1'b0;
        branchTaken = 1'b0;
        instrReady  = 1'b0;
        lat_left    = 0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        logic seen;
        logic br;
        logic rdy;

        do_reset();
        check32("reset_valid", 32'(instrValid), 32'h0);
        check32("reset_instrPC", instrPC, 32'h0);
        check32("reset_instruction", instruction, 32'h0);

        // Same-cycle acks with the decoder always ready
        repeat (12) drive_cycle(1'b1, 1'b0, 32'h0, 32'h0, 0, 1'b0);

        // Decoder stalled: buffer fills, request drops, then drains in order
        do_reset();
        repeat (6) drive_cycle(1'b0, 1'b0, 32'h0, 32'h0, 0, 1'b0);
        repeat (8) drive_cycle(1'b1, 1'b0, 32'h0, 32'h0, 0, 1'b0);

        // Redirect to 0x10 + (-2*4) = 0x08 while 0x14/0x18 are buffered
        do_reset();
        for (int i = 0; i < 20 && model_pc != 32'h10; i++)
            drive_cycle(1'b1, 1'b0, 32'h0, 32'h0, 0, 1'b0);
        drive_cycle(1'b1, 1'b0, 32'h0, 32'h0, 0, 1'b0);
        repeat (3) drive_cycle(1'b0, 1'b0, 32'h0, 32'h0, 0, 1'b0);
        drive_cycle(1'b1, 1'b1, 32'h10, 32'hFFFF_FFFE, 0, 1'b0);
        repeat (6) drive_cycle(1'b1, 1'b0, 32'h0, 32'h0, 0, 1'b0);

        // Redirect in the same cycle as the ack for 0x0C; target 0x30 + 4*4
        do_reset();
        for (int i = 0; i < 20 && model_pc != 32'h08; i++)
            drive_cycle(1'b1, 1'b0, 32'h0, 32'h0, 0, 1'b0);
        drive_cycle(1'b1, 1'b1, 32'h30, 32'h4, 0, 1'b1);
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            drive_cycle(1'b1, 1'b0, 32'h0, 32'h0, 0, 1'b0);
            @(negedge clk);
            if (instrValid) begin
                check32("redirect_first_pc", instrPC, 32'h40);
                seen = 1'b1;
            end
        end
        if (!seen) begin
            n_fail++;
            $display("FAIL redirect_first_pc: no instrValid within 10 cycles, expected pc 00000040");
        end

        // Slow memory, then reset while a request is waiting
        do_reset();
        repeat (4) drive_cycle(1'b1, 1'b0, 32'h0, 32'h0, 0, 1'b0);
        lat_left = 3;
        repeat (2) drive_cycle(1'b0, 1'b0, 32'h0, 32'h0, 3, 1'b0);
        @(posedge clk);
        #1;
        rst_n   = 1'b0;
        imemAck = 1'b0;
        #1;
        check32("midreset_valid", 32'(instrValid), 32'h0);
        check32("midreset_req", 32'(imemReq), 32'h0);
        check32("midreset_instrPC", instrPC, 32'h0);
        @(posedge clk);
        #1;
        rst_n    = 1'b1;
        lat_left = 0;
        repeat (6) drive_cycle(1'b1, 1'b0, 32'h0, 32'h0, 0, 1'b0);

        // Randomized traffic: variable latency, stalls, redirects, resets
        for (int i = 0; i < 3000; i++) begin
            br  = ($urandom_range(15, 0) == 0);
            rdy = ($urandom_range(3, 0) != 0);
            drive_cycle(rdy, br, $urandom, $urandom, 3, 1'b0);
            if ($urandom_range(499, 0) == 0) do_reset();
        end

        drive_cycle(1'b1, 1'b0, 32'h0, 32'h0, 0, 1'b0);
        @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        n_fail++;
        $display("FAIL watchdog: simulation did not complete by %0t", $time);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
